// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move driver.
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam logic [3:0] LAST_CELL = 4'd8;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  // Encoding of the game_status input coming back from the game.
  localparam logic [1:0] GS_DRAW        = 2'b00;
  localparam logic [1:0] GS_A_WINS      = 2'b01;
  localparam logic [1:0] GS_B_WINS      = 2'b10;
  localparam logic [1:0] GS_IN_PROGRESS = 2'b11;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_A     = 2'b01,
    CELL_B     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    RSP_ACCEPT    = 2'b00,
    RSP_OCCUPIED  = 2'b01,
    RSP_RANGE     = 2'b10,
    RSP_GAME_OVER = 2'b11
  } rsp_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } state_t;

  // True when the requested cell index addresses a real board cell.
  function automatic logic pos_in_range(input logic [3:0] p);
    return p <= LAST_CELL;
  endfunction

endpackage

// File: rtl/tic_tac_toe_driver_if.sv
// Host-side request/response handshake of the move driver.
interface tic_tac_toe_driver_if;
  logic       req_valid;
  logic [3:0] req_pos;
  logic       req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_code;

  // Host issuing move requests and collecting results.
  modport master (
    output req_valid, req_pos,
    input  req_ready, rsp_valid, rsp_code
  );

  // Driver accepting requests and producing results.
  modport slave (
    input  req_valid, req_pos,
    output req_ready, rsp_valid, rsp_code
  );
endinterface

// File: rtl/ttt_req_fifo.sv
// Two-entry request FIFO; pushes are ignored while full (no bypass).
module ttt_req_fifo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tic_tac_toe_driver.sv
// Move driver: queues host requests, validates them against a shadow board
// and the game status, and forwards legal moves to the game one at a time.
module tic_tac_toe_driver
  import ttt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  tic_tac_toe_driver_if.slave  host,
  output logic [3:0]           position,
  output logic                 player_select,
  output logic                 move_valid,
  input  logic                 current_turn,
  input  logic [1:0]           game_status
);

  state_t         state;
  logic [3:0]     pos_reg;
  rsp_code_t      code_reg;
  logic           rsp_valid_reg;
  logic           move_valid_reg;
  logic [3:0]     position_reg;
  logic           player_reg;
  logic [3:0]     move_cnt;
  logic           over_reg;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [3:0]     fifo_data;

  logic [NUM_CELLS-1:0] cell_busy;
  logic                 pos_busy;

  assign host.req_ready = !fifo_full;
  assign host.rsp_valid = rsp_valid_reg;
  assign host.rsp_code  = code_reg;
  assign position       = position_reg;
  assign player_select  = player_reg;
  assign move_valid     = move_valid_reg;

  // A new request is taken whenever the engine is waiting for work, including
  // after the game has ended so that late requests still get answered.
  assign fifo_pop = ((state == ST_IDLE) || (state == ST_DONE)) && !fifo_empty;

  ttt_req_fifo #(.WIDTH(4)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (host.req_valid),
    .push_data (host.req_pos),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Shadow board, one register per cell.
  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    cell_t cell_reg;

    // Record the mover in this cell during the cycle the move is issued.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cell_reg <= CELL_EMPTY;
      end else if (state == ST_ISSUE && position_reg == 4'(gi)) begin
        cell_reg <= player_reg ? CELL_A : CELL_B;
      end
    end

    assign cell_busy[gi] = (cell_reg != CELL_EMPTY);
  end

  assign pos_busy = pos_in_range(pos_reg) ? cell_busy[pos_reg] : 1'b0;

  // Request-processing FSM; strobes are registered so they are high exactly
  // while the FSM sits in ISSUE (move_valid) or RESP (rsp_valid).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      pos_reg        <= 4'd0;
      code_reg       <= RSP_ACCEPT;
      rsp_valid_reg  <= 1'b0;
      move_valid_reg <= 1'b0;
      position_reg   <= 4'd0;
      player_reg     <= 1'b1;
      move_cnt       <= 4'd0;
      over_reg       <= 1'b0;
    end else begin
      rsp_valid_reg  <= 1'b0;
      move_valid_reg <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (!fifo_empty) begin
            pos_reg <= fifo_data;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (over_reg || game_status != GS_IN_PROGRESS) begin
            code_reg      <= RSP_GAME_OVER;
            rsp_valid_reg <= 1'b1;
            state         <= ST_RESP;
          end else if (!pos_in_range(pos_reg)) begin
            code_reg      <= RSP_RANGE;
            rsp_valid_reg <= 1'b1;
            state         <= ST_RESP;
          end else if (pos_busy) begin
            code_reg      <= RSP_OCCUPIED;
            rsp_valid_reg <= 1'b1;
            state         <= ST_RESP;
          end else begin
            move_valid_reg <= 1'b1;
            position_reg   <= pos_reg;
            player_reg     <= current_turn;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          move_cnt <= move_cnt + 4'd1;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          code_reg      <= RSP_ACCEPT;
          rsp_valid_reg <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          // A full board counts as finished even if the game still says in progress.
          if (over_reg || game_status != GS_IN_PROGRESS || move_cnt == MAX_MOVES) begin
            over_reg <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tic_tac_toe_driver.md
TIC_TAC_TOE_DRIVER -- requirements
Module: tic_tac_toe_driver

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  1  host offers a move request.
REQ-004 SHALL have port: req_pos  input  4  requested cell, legal range 0..8.
REQ-005 SHALL have port: req_ready  output  1  request queue can accept.
REQ-006 SHALL have port: rsp_valid  output  1  one-cycle result strobe per request.
REQ-007 SHALL have port: rsp_code  output  2  00 ACCEPT, 01 OCCUPIED, 10 RANGE, 11 GAME_OVER.
REQ-008 SHALL have port: position  output  4  cell driven to game, held between moves.
REQ-009 SHALL have port: player_select  output  1  mover, 1 = player A, 0 = player B.
REQ-010 SHALL have port: move_valid  output  1  game commits position/player_select only in this cycle.
REQ-011 SHALL have port: current_turn  input  1  game's next mover.
REQ-012 SHALL have port: game_status  input  2  11 in progress, 01 A wins, 10 B wins, 00 draw.

Function
REQ-013 SHALL buffer requests in a 2-entry FIFO; push on req_valid && req_ready; req_ready = !full, no same-cycle bypass when full.
REQ-014 SHALL keep a 9-cell shadow board, each cell EMPTY/A/B, plus a 4-bit move count 0..9.
REQ-015 SHALL implement FSM states IDLE, CHECK, ISSUE, WAIT, RESP, DONE.
REQ-016 IDLE: FIFO non-empty -> pop, latch req_pos, go CHECK; else stay.
REQ-017 CHECK (1 cycle), first match wins: game_status != 11 -> code GAME_OVER; req_pos > 8 -> RANGE; cell not EMPTY -> OCCUPIED; else -> ISSUE.
REQ-018 Illegal request SHALL go RESP with its code; board and move count unchanged.
REQ-019 ISSUE: move_valid = 1 exactly one cycle, position = latched pos, player_select = current_turn; shadow cell set to that player, move count +1; go WAIT.
REQ-020 WAIT: one cycle for game update; then go RESP with code ACCEPT.
REQ-021 RESP: rsp_valid = 1 one cycle; next state DONE if game_status != 11, else IDLE.
REQ-022 DONE: every queued or later request SHALL be popped and answered GAME_OVER (CHECK -> RESP path); only reset leaves DONE.
REQ-023 Request-to-response latency: illegal 2 cycles (pop/CHECK, RESP); legal 4 cycles (CHECK, ISSUE, WAIT, RESP) after FIFO pop.
REQ-024 Move count reaching 9 with game_status still 11 SHALL force DONE after RESP.
REQ-025 position and player_select SHALL hold last issued values when move_valid = 0.
REQ-026 rsp_valid responses SHALL occur in request acceptance order, exactly one per accepted request.

Reset
REQ-027 On reset: FSM IDLE, FIFO empty, board all EMPTY, move count 0, req_ready 1 after deassert, rsp_valid 0, rsp_code 00, move_valid 0, position 0, player_select 1.
REQ-028 Reset mid-operation SHALL discard in-flight and queued requests without any response.

Structure
REQ-029 Package ttt_pkg SHALL hold cell enum (EMPTY/A/B), rsp_code enum, game_status constants, FSM state enum, NUM_CELLS = 9.
REQ-030 FIFO SHALL be sub-module ttt_req_fifo (depth 2, width 4, full/empty flags).

Verification
REQ-031 Reset, requests 0,1,3,4,6 -> five ACCEPT; player_select 1,0,1,0,1 on move_valid cycles; game_status 01 -> state DONE.
REQ-032 Request 4 twice -> first ACCEPT, second OCCUPIED, move_valid pulses once.
REQ-033 Request 9 and 15 -> RANGE each, no move_valid, board unchanged.
REQ-034 After A wins, request 2 -> GAME_OVER, no move_valid.
REQ-035 Back-to-back req_valid for 4 cycles -> req_ready low while 2 entries queued; all responses arrive in order.
REQ-036 Assert reset during ISSUE with one queued request -> move_valid low, no rsp_valid, board cleared, next request 0 -> ACCEPT by player A.
